// File: rtl/free_addr_pool_ctrl.sv
// Free-address pool controller: round-robin arbitration of allocators (pool reads)
// and releasers (pool writes) around a shared free-list FIFO. The last RESERVE
// addresses are kept for priority allocators.
module free_addr_pool_ctrl #(
  parameter int                 N_ALLOC    = 4,
  parameter int                 N_REL      = 2,
  parameter int                 ADDR_WIDTH = 6,
  parameter int                 RESERVE    = 4,
  parameter logic [N_ALLOC-1:0] PRIO_MASK  = 4'b0001
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_ALLOC-1:0]            alloc_req,
  output logic [N_ALLOC-1:0]            alloc_gnt,
  output logic [ADDR_WIDTH-1:0]         alloc_addr,
  input  logic [N_REL-1:0]              rel_valid,
  input  logic [N_REL*ADDR_WIDTH-1:0]   rel_addr,
  output logic [N_REL-1:0]              rel_ready,
  output logic                          pool_rd_en,
  input  logic [ADDR_WIDTH-1:0]         pool_rd_data,
  output logic                          pool_wr_en,
  output logic [ADDR_WIDTH-1:0]         pool_wr_data,
  input  logic                          pool_empty,
  input  logic                          pool_full,
  input  logic [ADDR_WIDTH:0]           pool_count,
  output logic [ADDR_WIDTH:0]           in_use,
  output logic                          ovf_err,
  output logic                          starve_err
);

  localparam int AIW = (N_ALLOC > 1) ? $clog2(N_ALLOC) : 1;
  localparam int RIW = (N_REL > 1) ? $clog2(N_REL) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH       = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] RESERVE_LVL = (ADDR_WIDTH+1)'(RESERVE);
  localparam logic [ADDR_WIDTH:0] CNT_MAX     = '1;

  logic                  pending_reg;
  logic [AIW-1:0]        pend_idx_reg;
  logic [AIW-1:0]        alloc_ptr_reg, alloc_ptr_next;
  logic [RIW-1:0]        rel_ptr_reg, rel_ptr_next;
  logic [ADDR_WIDTH-1:0] addr_hold_reg;
  logic [ADDR_WIDTH:0]   starve_cnt_reg, starve_cnt_next;
  logic                  ovf_err_reg, starve_err_reg;

  logic [N_ALLOC-1:0]    alloc_elig;
  logic                  above_reserve;
  logic                  alloc_found;
  logic [AIW-1:0]        alloc_sel, alloc_cand;
  logic                  rel_found, rel_take;
  logic [RIW-1:0]        rel_sel, rel_cand;
  logic [ADDR_WIDTH-1:0] rel_slice [N_REL];

  assign above_reserve = pool_count > RESERVE_LVL;

  // A requester already receiving its grant pulse is masked so it cannot win twice.
  genvar gi;
  generate
    for (gi = 0; gi < N_ALLOC; gi++) begin : g_alloc
      assign alloc_elig[gi] = alloc_req[gi] & ~pool_empty & (above_reserve | PRIO_MASK[gi])
                              & ~(pending_reg && (pend_idx_reg == AIW'(gi)));
      assign alloc_gnt[gi]  = pending_reg && (pend_idx_reg == AIW'(gi));
    end
    for (gi = 0; gi < N_REL; gi++) begin : g_rel
      assign rel_slice[gi] = rel_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign rel_ready[gi] = rel_take && rst_n && (rel_sel == RIW'(gi));
    end
  endgenerate

  // Allocation arbiter: first eligible requester at or after alloc_ptr.
  always_comb begin
    alloc_found = 1'b0;
    alloc_sel   = '0;
    alloc_cand  = '0;
    for (int k = 0; k < N_ALLOC; k++) begin
      alloc_cand = AIW'((int'(alloc_ptr_reg) + k) % N_ALLOC);
      if (!alloc_found && alloc_elig[alloc_cand]) begin
        alloc_found = 1'b1;
        alloc_sel   = alloc_cand;
      end
    end
    alloc_ptr_next = AIW'((int'(alloc_sel) + 1) % N_ALLOC);
  end

  // Release arbiter: first valid releaser at or after rel_ptr; refused while the pool is full.
  always_comb begin
    rel_found = 1'b0;
    rel_sel   = '0;
    rel_cand  = '0;
    for (int k = 0; k < N_REL; k++) begin
      rel_cand = RIW'((int'(rel_ptr_reg) + k) % N_REL);
      if (!rel_found && rel_valid[rel_cand]) begin
        rel_found = 1'b1;
        rel_sel   = rel_cand;
      end
    end
    rel_take     = rel_found & ~pool_full;
    rel_ptr_next = RIW'((int'(rel_sel) + 1) % N_REL);
  end

  // Starvation counter: counts blocked request cycles, saturating, cleared by any grant.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (alloc_found)
      starve_cnt_next = '0;
    else if (|alloc_req && starve_cnt_reg != CNT_MAX)
      starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  // Allocation pipeline: stage-0 decision registered into the grant stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= 1'b0;
      pend_idx_reg  <= '0;
      alloc_ptr_reg <= '0;
      addr_hold_reg <= '0;
    end else begin
      pending_reg <= alloc_found;
      if (alloc_found) begin
        pend_idx_reg  <= alloc_sel;
        alloc_ptr_reg <= alloc_ptr_next;
      end
      if (pending_reg)
        addr_hold_reg <= pool_rd_data;
    end
  end

  // Release pointer advances only on an accepted release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rel_ptr_reg <= '0;
    else if (rel_take)
      rel_ptr_reg <= rel_ptr_next;
  end

  // Sticky error flags and the starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_reg    <= 1'b0;
      starve_err_reg <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (|rel_valid && pool_full)
        ovf_err_reg <= 1'b1;
      if (starve_cnt_next > DEPTH)
        starve_err_reg <= 1'b1;
    end
  end

  // Pool read data arrives in the grant cycle, so it is passed straight through then held.
  assign alloc_addr   = pending_reg ? pool_rd_data : addr_hold_reg;
  assign pool_rd_en   = alloc_found & rst_n;
  assign pool_wr_en   = rel_take & rst_n;
  assign pool_wr_data = rel_slice[rel_sel];
  assign in_use       = DEPTH - pool_count;
  assign ovf_err      = ovf_err_reg;
  assign starve_err   = starve_err_reg;

endmodule

// File: tb/tb_free_addr_pool_ctrl.sv
// Randomized bench for free_addr_pool_ctrl: an emulated pool FIFO driven by the DUT's
// strobes, plus a free-list reference model predicting grants, releases and errors.
module tb_free_addr_pool_ctrl;
  localparam int NA = 4;
  localparam int NR = 2;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int RSV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NA-1:0] alloc_req, alloc_gnt;
  logic [AW-1:0] alloc_addr;
  logic [NR-1:0] rel_valid, rel_ready;
  logic [NR*AW-1:0] rel_addr;
  logic pool_rd_en, pool_wr_en, pool_empty, pool_full, ovf_err, starve_err;
  logic [AW-1:0] pool_rd_data, pool_wr_data;
  logic [AW:0] pool_count, in_use;

  free_addr_pool_ctrl #(.N_ALLOC(NA), .N_REL(NR), .ADDR_WIDTH(AW), .RESERVE(RSV),
                        .PRIO_MASK(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_addr(alloc_addr), .rel_valid(rel_valid), .rel_addr(rel_addr),
    .rel_ready(rel_ready), .pool_rd_en(pool_rd_en), .pool_rd_data(pool_rd_data),
    .pool_wr_en(pool_wr_en), .pool_wr_data(pool_wr_data), .pool_empty(pool_empty),
    .pool_full(pool_full), .pool_count(pool_count), .in_use(in_use),
    .ovf_err(ovf_err), .starve_err(starve_err));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // emulated pool FIFO
  int pool_q[$];
  // reference model
  int m_free[$];
  int m_ptr, m_rptr, m_pidx, m_last, m_served, m_scnt;
  bit m_pend, m_ovf, m_serr;
  logic [NA-1:0] prio = 4'b0001;
  // requester/releaser stimulus state
  logic [NA-1:0] want;
  logic [NR-1:0] rvalid;
  int raddr[NR];
  int held[$];
  int gnt_prev;
  logic [NA-1:0] req_mask;
  int p_req, p_rel;
  bit did_rst;

  task automatic env_drive();
    pool_count = (AW+1)'(pool_q.size());
    pool_empty = (pool_q.size() == 0);
    pool_full  = (pool_q.size() == DEPTH);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_rptr = 0; m_pidx = 0; m_last = 0; m_served = 0; m_scnt = 0;
    m_pend = 0; m_ovf = 0; m_serr = 0; gnt_prev = -1;
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic run_cycle(input bit rst_mid);
    int n, exp_sel, rsel, idx, i, j;
    bit above, any_rel;
    logic e_rd, e_wr;
    int e_wd;
    for (int a = 0; a < NA; a++) begin
      if (gnt_prev == a) want[a] = 1'b0;
      if (!want[a] && req_mask[a] && int'($urandom_range(99)) < p_req) want[a] = 1'b1;
    end
    for (int r = 0; r < NR; r++) begin
      if (!rvalid[r] && held.size() > 0 && int'($urandom_range(99)) < p_rel) begin
        idx = int'($urandom_range(held.size() - 1));
        raddr[r] = held[idx];
        held.delete(idx);
        rvalid[r] = 1'b1;
      end
    end
    alloc_req = want;
    rel_valid = rvalid;
    for (int r = 0; r < NR; r++) rel_addr[r*AW +: AW] = raddr[r][AW-1:0];
    #1;
    n = m_free.size();
    above = n > RSV;
    exp_sel = -1;
    for (int k = 0; k < NA; k++) begin
      i = (m_ptr + k) % NA;
      if (exp_sel < 0 && want[i] && n > 0 && (above || prio[i]) && !(m_pend && m_pidx == i))
        exp_sel = i;
    end
    any_rel = |rvalid;
    rsel = -1;
    if (any_rel && n < DEPTH)
      for (int k = 0; k < NR; k++) begin
        j = (m_rptr + k) % NR;
        if (rsel < 0 && rvalid[j]) rsel = j;
      end
    chk("alloc_gnt", int'(alloc_gnt), m_pend ? (1 << m_pidx) : 0);
    chk("alloc_addr", int'(alloc_addr), m_pend ? m_served : m_last);
    chk("pool_rd_en", int'(pool_rd_en), int'(exp_sel >= 0));
    chk("rel_ready", int'(rel_ready), rsel >= 0 ? (1 << rsel) : 0);
    chk("pool_wr_en", int'(pool_wr_en), int'(rsel >= 0));
    if (rsel >= 0) chk("pool_wr_data", int'(pool_wr_data), raddr[rsel]);
    chk("in_use", int'(in_use), DEPTH - n);
    chk("ovf_err", int'(ovf_err), int'(m_ovf));
    chk("starve_err", int'(starve_err), int'(m_serr));
    if (m_pend) $display("grant req=%0d addr=%0d", m_pidx, m_served);
    if (rsel >= 0) $display("release rel=%0d addr=%0d", rsel, raddr[rsel]);
    e_rd = pool_rd_en; e_wr = pool_wr_en; e_wd = int'(pool_wr_data);
    // model next state
    gnt_prev = m_pend ? m_pidx : -1;
    if (m_pend) begin
      m_last = m_served;
      held.push_back(m_served);
    end
    if (exp_sel >= 0) begin
      m_served = m_free.pop_front();
      m_pend = 1; m_pidx = exp_sel; m_ptr = (exp_sel + 1) % NA; m_scnt = 0;
    end else begin
      m_pend = 0;
      if (|want && m_scnt < 2*DEPTH - 1) m_scnt++;
    end
    if (m_scnt > DEPTH) m_serr = 1;
    if (any_rel && n == DEPTH) m_ovf = 1;
    if (rsel >= 0) begin
      m_free.push_back(raddr[rsel]);
      rvalid[rsel] = 1'b0;
      m_rptr = (rsel + 1) % NR;
    end
    @(posedge clk);
    #1;
    if (rst_mid && exp_sel >= 0) begin
      rst_n = 1'b0;
      #1;
      chk("rst_mid_gnt", int'(alloc_gnt), 0);
      chk("rst_mid_addr", int'(alloc_addr), 0);
      chk("rst_mid_rd_en", int'(pool_rd_en), 0);
      did_rst = 1;
    end
    if (e_rd) pool_rd_data = AW'(pool_q.pop_front());
    if (e_wr) pool_q.push_back(e_wd);
    env_drive();
    @(negedge clk);
    if (did_rst && !rst_n) begin
      model_reset();
      rst_n = 1'b1;
    end
  endtask

  task automatic run_phase(input int cycles, input logic [NA-1:0] mask, input int preq, input int prel);
    req_mask = mask; p_req = preq; p_rel = prel;
    for (int c = 0; c < cycles; c++) run_cycle(1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    pool_q.delete(); m_free.delete(); held.delete();
    for (int a = 0; a < DEPTH; a++) begin pool_q.push_back(a); m_free.push_back(a); end
    pool_rd_data = '0;
    env_drive();
    want = '1; rvalid = '1; raddr[0] = 5; raddr[1] = 9;
    alloc_req = want; rel_valid = rvalid;
    rel_addr = '0;
    did_rst = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_gnt", int'(alloc_gnt), 0);
    chk("reset_addr", int'(alloc_addr), 0);
    chk("reset_rd_en", int'(pool_rd_en), 0);
    chk("reset_wr_en", int'(pool_wr_en), 0);
    chk("reset_rel_ready", int'(rel_ready), 0);
    chk("reset_ovf", int'(ovf_err), 0);
    chk("reset_starve", int'(starve_err), 0);
    chk("reset_in_use", int'(in_use), 0);
    want = '0; rvalid = '0;
    rst_n = 1'b1;
    // double free into a full pool
    req_mask = '0; p_req = 0; p_rel = 0;
    rvalid[0] = 1'b1; raddr[0] = 7;
    repeat (3) run_cycle(1'b0);
    chk("ovf_sticky_set", int'(ovf_err), 1);
    rvalid = '0;
    run_phase(2, 4'b0000, 0, 0);
    // mixed traffic
    run_phase(400, 4'b1111, 60, 30);
    // non-priority requesters only, no releases: reserve blocks them
    run_phase(300, 4'b1110, 100, 0);
    chk("starve_set", int'(starve_err), 1);
    // priority requester consumes the reserve
    run_phase(100, 4'b0001, 100, 0);
    chk("pool_drained", int'(pool_empty), 1);
    chk("no_rd_when_empty", int'(pool_rd_en), 0);
    // refill and mixed traffic
    run_phase(300, 4'b1111, 30, 60);
    run_phase(100, 4'b0000, 0, 100);
    // reset in the grant cycle after a stage-0 decision
    want = '1; req_mask = 4'b1111; p_req = 100; p_rel = 0;
    for (int c = 0; c < 50 && !did_rst; c++) run_cycle(1'b1);
    chk("post_rst_ovf", int'(ovf_err), 0);
    chk("post_rst_starve", int'(starve_err), 0);
    run_phase(60, 4'b1111, 80, 40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
